// File: rtl/cpu_bus_pkg.sv
// Shared types and sizing helpers for the 65C02 bus phaser.
package cpu_bus_pkg;

   typedef enum logic [1:0] {
      PH_LOW  = 2'd0,
      PH_HIGH = 2'd1,
      PH_HOLD = 2'd2
   } phase_t;

   localparam logic STROBE_IDLE = 1'b1;

   localparam int PHI2_LOW_TICKS_DEF  = 4;
   localparam int PHI2_HIGH_TICKS_DEF = 4;
   localparam int MAX_WAIT_DEF        = 8;

   // Counter must cover the longest phase, including a fully stretched PHI2-high.
   function automatic int tick_cnt_w(input int low_ticks, input int high_ticks, input int max_wait);
      int m;
      m = (low_ticks > high_ticks + max_wait) ? low_ticks : high_ticks + max_wait;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/cpu_bus_phaser_phase_counter.sv
// phase_counter: loadable down-counter with hold; tc flags the last tick of a phase.
module phase_counter
   import cpu_bus_pkg::*;
#(
   parameter int           W       = 4,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk6x,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         hold,
   output logic [W-1:0] count,
   output logic         tc
);

   always_ff @(posedge clk6x) begin
      if (reset) begin
         count <= RST_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (!hold && count != '0) begin
         count <= count - W'(1);
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/cpu_bus_phaser.sv
// cpu_bus_phaser: 65C02 bus-cycle responder; generates CPHI2 from clk6x and sequences SRAM strobes.
// Optional PHI2-high wait states are enabled by defining CPU_WAITSTATE_EN.
//
// state   | meaning
// PH_LOW  | PHI2 low; CA/CRWn latched on the last tick
// PH_HIGH | PHI2 high; SRAM strobes active, CD driven on reads
// PH_HOLD | parked with PHI2 low until run_i returns
module cpu_bus_phaser
   import cpu_bus_pkg::*;
#(
   parameter int PHI2_LOW_TICKS  = PHI2_LOW_TICKS_DEF,
   parameter int PHI2_HIGH_TICKS = PHI2_HIGH_TICKS_DEF,
   parameter int MAX_WAIT        = MAX_WAIT_DEF
) (
   input  logic        clk6x,
   input  logic        reset,
   input  logic        run_i,
   input  logic [15:0] cpu_a_i,
   input  logic        cpu_rwn_i,
   input  logic [7:0]  cpu_db_i,
   output logic [7:0]  cpu_db_o,
   output logic        cpu_db_oe,
   output logic        cphi2_o,
   output logic        cycle_start_o,
   output logic [15:0] lat_addr_o,
   output logic        lat_rwn_o,
   input  logic        mem_sel_i,
   input  logic [7:0]  mem_rdata_i,
   output logic        mem_csn_o,
   output logic        mem_rdn_o,
   output logic        mem_wrn_o,
   output logic [7:0]  wdata_o,
   input  logic        wait_i,
   output logic        wait_timeout_o
);

   localparam int            TW        = tick_cnt_w(PHI2_LOW_TICKS, PHI2_HIGH_TICKS, MAX_WAIT);
   localparam logic [TW-1:0] LOW_LOAD  = TW'(PHI2_LOW_TICKS - 1);
   localparam logic [TW-1:0] HIGH_LOAD = TW'(PHI2_HIGH_TICKS - 1);

   generate
      if (PHI2_LOW_TICKS < 2) begin : g_bad_low
         $error("cpu_bus_phaser: PHI2_LOW_TICKS must be >= 2");
      end
      if (PHI2_HIGH_TICKS < 3) begin : g_bad_high
         $error("cpu_bus_phaser: PHI2_HIGH_TICKS must be >= 3");
      end
   endgenerate

   phase_t        state, state_nxt;
   logic [TW-1:0] count, load_val;
   logic          load, hold, tc;
   logic          in_high, rd_cyc, wr_cyc;
   logic [15:0]   lat_addr_q;
   logic          lat_rwn_q;
   logic [7:0]    rd_q, wd_q;
   logic          oe_hold_q;

   phase_counter #(.W(TW), .RST_VAL(LOW_LOAD)) u_phase_counter (
      .clk6x    (clk6x),
      .reset    (reset),
      .load     (load),
      .load_val (load_val),
      .hold     (hold),
      .count    (count),
      .tc       (tc)
   );

   assign in_high = (state == PH_HIGH);
   assign rd_cyc  = in_high &&  lat_rwn_q;
   assign wr_cyc  = in_high && !lat_rwn_q;

`ifdef CPU_WAITSTATE_EN
   localparam int WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   logic [WW-1:0] wait_cnt_q;
   logic          wait_req;

   // Stretch happens on the second-to-last high tick so the final tick stays intact.
   assign wait_req       = in_high && (count == TW'(1)) && wait_i;
   assign hold           = wait_req && (wait_cnt_q != WW'(MAX_WAIT));
   assign wait_timeout_o = wait_req && (wait_cnt_q == WW'(MAX_WAIT));

   always_ff @(posedge clk6x) begin
      if (reset || !in_high) begin
         wait_cnt_q <= '0;
      end else if (hold) begin
         wait_cnt_q <= wait_cnt_q + WW'(1);
      end
   end
`else
   logic wait_unused;
   assign wait_unused    = wait_i;
   assign hold           = 1'b0;
   assign wait_timeout_o = 1'b0;
`endif

   always_comb begin
      state_nxt     = state;
      load          = 1'b0;
      load_val      = LOW_LOAD;
      cycle_start_o = 1'b0;
      unique case (state)
         PH_LOW: begin
            if (tc) begin
               cycle_start_o = 1'b1;
               state_nxt     = PH_HIGH;
               load          = 1'b1;
               load_val      = HIGH_LOAD;
            end
         end
         PH_HIGH: begin
            if (tc) begin
               state_nxt = run_i ? PH_LOW : PH_HOLD;
               load      = 1'b1;
            end
         end
         PH_HOLD: begin
            if (run_i) begin
               state_nxt = PH_LOW;
               load      = 1'b1;
            end
         end
         default: begin
            state_nxt = PH_LOW;
            load      = 1'b1;
         end
      endcase
   end

   // Strobes come straight from state so they all release on the same edge as PHI2.
   always_comb begin
      cphi2_o   = 1'b0;
      mem_csn_o = STROBE_IDLE;
      mem_rdn_o = STROBE_IDLE;
      mem_wrn_o = STROBE_IDLE;
      if (in_high) begin
         cphi2_o   = 1'b1;
         mem_csn_o = ~mem_sel_i;
         mem_rdn_o = ~(mem_sel_i & lat_rwn_q);
         mem_wrn_o = ~(mem_sel_i & ~lat_rwn_q & (count != HIGH_LOAD));
      end
   end

   assign cpu_db_o   = rd_cyc ? mem_rdata_i : rd_q;
   assign cpu_db_oe  = rd_cyc | oe_hold_q;
   assign wdata_o    = wr_cyc ? cpu_db_i : wd_q;
   assign lat_addr_o = lat_addr_q;
   assign lat_rwn_o  = lat_rwn_q;

   always_ff @(posedge clk6x) begin
      if (reset) begin
         state      <= PH_LOW;
         lat_addr_q <= '0;
         lat_rwn_q  <= 1'b0;
         rd_q       <= '0;
         wd_q       <= '0;
         oe_hold_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (cycle_start_o) begin
            lat_addr_q <= cpu_a_i;
            lat_rwn_q  <= cpu_rwn_i;
         end
         if (rd_cyc) rd_q <= mem_rdata_i;
         if (wr_cyc) wd_q <= cpu_db_i;
         // One extra tick of CD drive after PHI2 falls covers the CPU's data hold time.
         oe_hold_q <= rd_cyc && (state_nxt != PH_HIGH);
      end
   end

endmodule
